// File: rtl/rv_pkg.sv
// Shared constants and types for the load/store unit.
// Contents: RISC-V LOAD/STORE opcodes, funct3 width selects, LSU FSM state enum.
// No ports; imported by rv_lsu and rv_lsu_align.
package rv_pkg;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    DONE,
    FAULT
  } lsu_state_t;

endpackage

// File: rtl/rv_lsu_align.sv
// Combinational lane logic for the LSU: load extraction with sign/zero extension,
// store lane replication with byte enables, and illegal/misaligned access detection.
// Ports: i_is_store, i_funct3, i_off (addr[1:0]), i_store_data, i_rdata -> o_wdata, o_be, o_load_data, o_illegal.
module rv_lsu_align
  import rv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             i_is_store,
  input  logic [2:0]       i_funct3,
  input  logic [1:0]       i_off,
  input  logic [WIDTH-1:0] i_store_data,
  input  logic [WIDTH-1:0] i_rdata,
  output logic [WIDTH-1:0] o_wdata,
  output logic [3:0]       o_be,
  output logic [WIDTH-1:0] o_load_data,
  output logic             o_illegal
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Load extraction: select the addressed byte/half out of the raw word.
  always_comb begin
    w_byte      = i_rdata[{i_off, 3'b000} +: 8];
    w_half      = i_off[1] ? i_rdata[31:16] : i_rdata[15:0];
    o_load_data = i_rdata;
    case (i_funct3)
      F3_B:    o_load_data = {{(WIDTH-8){w_byte[7]}}, w_byte};
      F3_BU:   o_load_data = {{(WIDTH-8){1'b0}}, w_byte};
      F3_H:    o_load_data = {{(WIDTH-16){w_half[15]}}, w_half};
      F3_HU:   o_load_data = {{(WIDTH-16){1'b0}}, w_half};
      default: o_load_data = i_rdata;
    endcase
  end

  // Store lanes: data is replicated across the word so the byte enables alone
  // pick the destination lane.
  always_comb begin
    o_wdata = i_store_data;
    o_be    = 4'b1111;
    case (i_funct3[1:0])
      2'b00: begin
        o_wdata = {4{i_store_data[7:0]}};
        o_be    = 4'b0001 << i_off;
      end
      2'b01: begin
        o_wdata = {2{i_store_data[15:0]}};
        o_be    = i_off[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        o_wdata = i_store_data;
        o_be    = 4'b1111;
      end
    endcase
    if (!i_is_store) o_be = 4'b0000;
  end

  // Illegal encodings plus natural-alignment check for half/word accesses.
  always_comb begin
    if (i_is_store) o_illegal = (i_funct3 >= 3'b011);
    else            o_illegal = (i_funct3 == 3'b011) || (i_funct3[2:1] == 2'b11);
    if ((i_funct3[1:0] == 2'b01) && i_off[0])         o_illegal = 1'b1;
    if ((i_funct3[1:0] == 2'b10) && (i_off != 2'b00)) o_illegal = 1'b1;
  end

endmodule

// File: rtl/rv_lsu.sv
// Load/store unit: one request/response transaction per LOAD/STORE, aligned load data to Mem_data.
// Ports: clk/rst; start/opcode/funct3/addr/store_data from execute; busy/done/fault/Mem_data to pipeline;
//        mem_req_* / mem_we / mem_addr / mem_wdata / mem_be / mem_rsp_* to the data-memory port.
module rv_lsu
  import rv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [6:0]       opcode,
  input  logic [2:0]       funct3,
  input  logic [WIDTH-1:0] addr,
  input  logic [WIDTH-1:0] store_data,
  output logic             busy,
  output logic             done,
  output logic             fault,
  output logic [WIDTH-1:0] Mem_data,
  output logic             mem_req_valid,
  input  logic             mem_req_ready,
  output logic             mem_we,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  output logic [3:0]       mem_be,
  input  logic             mem_rsp_valid,
  input  logic [WIDTH-1:0] mem_rsp_rdata
);

  lsu_state_t       r_state;
  lsu_state_t       w_next;
  logic [6:0]       r_opcode;
  logic [2:0]       r_funct3;
  logic [WIDTH-1:0] r_addr;
  logic [WIDTH-1:0] r_store_data;
  logic [WIDTH-1:0] r_mem_data;

  logic             w_idle;
  logic             w_mem_op;
  logic             w_r_store;
  logic             w_sel_store;
  logic [2:0]       w_sel_funct3;
  logic [1:0]       w_sel_off;
  logic [WIDTH-1:0] w_sel_sdata;
  logic [WIDTH-1:0] w_wdata;
  logic [3:0]       w_be;
  logic [WIDTH-1:0] w_load_data;
  logic             w_illegal;

  assign w_idle    = (r_state == IDLE);
  assign w_mem_op  = (opcode == OP_LOAD) || (opcode == OP_STORE);
  assign w_r_store = (r_opcode == OP_STORE);

  // One align block serves both phases: in IDLE it classifies the incoming
  // instruction (legality decides REQ vs FAULT), afterwards it works on the
  // latched request. Its data outputs are only consumed outside IDLE.
  assign w_sel_store  = w_idle ? (opcode == OP_STORE) : w_r_store;
  assign w_sel_funct3 = w_idle ? funct3 : r_funct3;
  assign w_sel_off    = w_idle ? addr[1:0] : r_addr[1:0];
  assign w_sel_sdata  = w_idle ? store_data : r_store_data;

  rv_lsu_align #(.WIDTH(WIDTH)) u_align (
    .i_is_store   (w_sel_store),
    .i_funct3     (w_sel_funct3),
    .i_off        (w_sel_off),
    .i_store_data (w_sel_sdata),
    .i_rdata      (mem_rsp_rdata),
    .o_wdata      (w_wdata),
    .o_be         (w_be),
    .o_load_data  (w_load_data),
    .o_illegal    (w_illegal)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_opcode     <= '0;
      r_funct3     <= '0;
      r_addr       <= '0;
      r_store_data <= '0;
      r_mem_data   <= '0;
    end else begin
      r_state <= w_next;
      // Fields only load from IDLE, so a start while busy cannot disturb them.
      if (w_idle && start && w_mem_op) begin
        r_opcode     <= opcode;
        r_funct3     <= funct3;
        r_addr       <= addr;
        r_store_data <= store_data;
      end
      if ((r_state == WAIT) && mem_rsp_valid) r_mem_data <= w_load_data;
    end
  end

  always_comb begin
    w_next        = r_state;
    busy          = !w_idle;
    done          = 1'b0;
    fault         = 1'b0;
    mem_req_valid = 1'b0;
    mem_we        = 1'b0;
    mem_addr      = '0;
    mem_wdata     = '0;
    mem_be        = 4'b0000;
    case (r_state)
      IDLE: begin
        if (start && w_mem_op) w_next = w_illegal ? FAULT : REQ;
      end
      REQ: begin
        mem_req_valid = 1'b1;
        mem_we        = w_r_store;
        mem_addr      = {r_addr[WIDTH-1:2], 2'b00};
        mem_wdata     = w_wdata;
        mem_be        = w_be;
        if (mem_req_ready) w_next = w_r_store ? DONE : WAIT;
      end
      WAIT: begin
        if (mem_rsp_valid) w_next = DONE;
      end
      DONE: begin
        done   = 1'b1;
        w_next = IDLE;
      end
      FAULT: begin
        fault  = 1'b1;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  assign Mem_data = r_mem_data;

endmodule

// File: tb/tb_rv_lsu.sv
module tb_rv_lsu;
  import rv_pkg::*;

  logic        clk;
  logic        rst;
  logic        start;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] store_data;
  logic        busy;
  logic        done;
  logic        fault;
  logic [31:0] Mem_data;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_rdata;

  rv_lsu #(.WIDTH(32)) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .opcode        (opcode),
    .funct3        (funct3),
    .addr          (addr),
    .store_data    (store_data),
    .busy          (busy),
    .done          (done),
    .fault         (fault),
    .Mem_data      (Mem_data),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_we        (mem_we),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_be        (mem_be),
    .mem_rsp_valid (mem_rsp_valid),
    .mem_rsp_rdata (mem_rsp_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        chk_w;
  } req_t;

  typedef struct packed {
    logic        is_fault;
    logic        chk_data;
    logic [31:0] data;
  } cmp_t;

  req_t req_q[$];
  cmp_t cmp_q[$];
  req_t mon_r;
  cmp_t mon_c;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compares every accepted request and every done/fault pulse
  // against the expectations queued by the stimulus.
  always @(negedge clk) begin
    if (!rst) begin
      if (mem_req_valid && mem_req_ready) begin
        if (req_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_req: addr 0x%08h with no request expected", mem_addr);
        end else begin
          mon_r = req_q.pop_front();
          chk("req_we",   {31'b0, mem_we}, {31'b0, mon_r.we});
          chk("req_addr", mem_addr, mon_r.addr);
          if (mon_r.chk_w) chk("req_wdata", mem_wdata, mon_r.wdata);
          chk("req_be",   {28'b0, mem_be}, {28'b0, mon_r.be});
        end
      end
      if (done || fault) begin
        if (cmp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_cmp: done=%0b fault=%0b with nothing expected", done, fault);
        end else begin
          mon_c = cmp_q.pop_front();
          chk("cmp_fault", {31'b0, fault}, {31'b0, mon_c.is_fault});
          chk("cmp_done",  {31'b0, done},  {31'b0, !mon_c.is_fault});
          if (done && mon_c.chk_data) chk("mem_data", Mem_data, mon_c.data);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents the instruction for one cycle (T); returns 1ns into cycle T+1.
  task automatic issue(input logic [6:0] op, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] d);
    start = 1'b1; opcode = op; funct3 = f3; addr = a; store_data = d;
    step();
    start = 1'b0; opcode = '0; funct3 = '0; addr = '0; store_data = '0;
  endtask

  // Ready at T+1, response at T+3, done expected at T+4. A junk response is
  // driven while in REQ and must be ignored.
  task automatic do_load(input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] rdata, input logic [31:0] exp);
    req_q.push_back('{we: 1'b0, addr: {a[31:2], 2'b00}, wdata: 32'h0, be: 4'b0000, chk_w: 1'b0});
    cmp_q.push_back('{is_fault: 1'b0, chk_data: 1'b1, data: exp});
    issue(OP_LOAD, f3, a, 32'h0);
    mem_req_ready = 1'b1;
    mem_rsp_valid = 1'b1; mem_rsp_rdata = 32'h5555_5555;
    step();
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b0;
    step();
    mem_rsp_valid = 1'b1; mem_rsp_rdata = rdata;
    step();
    mem_rsp_valid = 1'b0;
    chk("load_done_at_T4", {31'b0, done}, 32'd1);
    step();
  endtask

  // Ready held low for 'stall' REQ cycles; a start during the stall must be ignored.
  task automatic do_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d,
                          input logic [31:0] wexp, input logic [3:0] bexp, input int stall);
    req_q.push_back('{we: 1'b1, addr: {a[31:2], 2'b00}, wdata: wexp, be: bexp, chk_w: 1'b1});
    cmp_q.push_back('{is_fault: 1'b0, chk_data: 1'b0, data: 32'h0});
    issue(OP_STORE, f3, a, d);
    for (int i = 0; i < stall; i++) begin
      chk("stall_valid", {31'b0, mem_req_valid}, 32'd1);
      chk("stall_addr",  mem_addr, {a[31:2], 2'b00});
      chk("stall_wdata", mem_wdata, wexp);
      chk("stall_be",    {28'b0, mem_be}, {28'b0, bexp});
      chk("stall_busy",  {31'b0, busy}, 32'd1);
      chk("stall_done",  {31'b0, done}, 32'd0);
      start = (i == 1); opcode = OP_LOAD; funct3 = F3_W; addr = 32'h500;
      step();
    end
    start = 1'b0; opcode = '0; funct3 = '0; addr = '0;
    mem_req_ready = 1'b1;
    step();
    mem_req_ready = 1'b0;
    chk("store_done_next", {31'b0, done}, 32'd1);
    step();
  endtask

  task automatic do_fault(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] a);
    cmp_q.push_back('{is_fault: 1'b1, chk_data: 1'b0, data: 32'h0});
    issue(op, f3, a, 32'h0);
    chk("fault_at_T1",    {31'b0, fault}, 32'd1);
    chk("fault_no_req",   {31'b0, mem_req_valid}, 32'd0);
    chk("fault_no_done",  {31'b0, done}, 32'd0);
    step();
    chk("fault_then_idle", {31'b0, busy}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; opcode = '0; funct3 = '0; addr = '0; store_data = '0;
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_rdata = '0;
    step();
    step();
    chk("rst_busy",  {31'b0, busy}, 32'd0);
    chk("rst_done",  {31'b0, done}, 32'd0);
    chk("rst_fault", {31'b0, fault}, 32'd0);
    chk("rst_mem_data", Mem_data, 32'h0);
    chk("rst_req_valid", {31'b0, mem_req_valid}, 32'd0);
    chk("rst_req_fields", {mem_we, mem_be, 27'b0} | mem_addr | mem_wdata, 32'h0);
    rst = 1'b0;
    step();

    do_load(F3_W,  32'h100, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
    do_load(F3_B,  32'h103, 32'h80FF_0000, 32'hFFFF_FF80);
    do_load(F3_BU, 32'h103, 32'h80FF_0000, 32'h0000_0080);
    do_load(F3_H,  32'h100, 32'h0000_8001, 32'hFFFF_8001);
    do_load(F3_HU, 32'h102, 32'hABCD_1234, 32'h0000_ABCD);

    do_store(F3_B, 32'h201, 32'h1234_56AA, 32'hAAAA_AAAA, 4'b0010, 0);
    chk("mem_data_held_after_store", Mem_data, 32'h0000_ABCD);
    do_store(F3_H, 32'h202, 32'h0000_BEEF, 32'hBEEF_BEEF, 4'b1100, 0);
    do_store(F3_W, 32'h300, 32'h1122_3344, 32'h1122_3344, 4'b1111, 5);

    do_fault(OP_LOAD,  F3_W,   32'h102);
    do_fault(OP_STORE, 3'b011, 32'h400);

    // Non-memory opcode is ignored.
    issue(7'b0110011, F3_W, 32'h100, 32'h0);
    chk("other_opcode_idle", {31'b0, busy}, 32'd0);

    // Reset while waiting for the load response.
    req_q.push_back('{we: 1'b0, addr: 32'h104, wdata: 32'h0, be: 4'b0000, chk_w: 1'b0});
    issue(OP_LOAD, F3_W, 32'h104, 32'h0);
    mem_req_ready = 1'b1;
    step();
    mem_req_ready = 1'b0;
    chk("wait_busy", {31'b0, busy}, 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst_mid_busy", {31'b0, busy}, 32'd0);
    chk("rst_mid_mem_data", Mem_data, 32'h0);
    chk("rst_mid_req_valid", {31'b0, mem_req_valid}, 32'd0);
    mem_rsp_valid = 1'b1; mem_rsp_rdata = 32'h7777_7777;
    step();
    mem_rsp_valid = 1'b0;
    chk("late_rsp_no_done", {31'b0, done}, 32'd0);
    chk("late_rsp_mem_data", Mem_data, 32'h0);
    step();

    do_load(F3_W, 32'h108, 32'hCAFE_F00D, 32'hCAFE_F00D);

    step();
    step();
    chk("req_q_drained", req_q.size(), 32'd0);
    chk("cmp_q_drained", cmp_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
